// File: rtl/stage_mem_update_ctrl_pkg.sv
// Shared types for the stage table-update controller: command opcodes,
// sequencer states and a table-depth helper.
package stage_mem_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_CLR = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_CAPT,
    ST_RSP,
    ST_CLEAR
  } state_e;

  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/stage_mem_update_ctrl_if.sv
// Command and read-back response channels of the table-update controller.
interface stage_mem_update_ctrl_if
  import stage_mem_pkg::*;
#(
  parameter int DATA = 72,
  parameter int ADDR = 10
) ();

  logic            cmd_valid;
  logic            cmd_ready;
  op_e             cmd_op;
  logic [ADDR-1:0] cmd_addr;
  logic [ADDR-1:0] cmd_last;
  logic [DATA-1:0] cmd_data;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [ADDR-1:0] rsp_addr;
  logic [DATA-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_last, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_last, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data
  );

endinterface

// File: rtl/stage_mem_update_ctrl.sv
// Port-B sequencer for a lookup stage's table RAM: single writes, read-backs
// with a held response, and range clears that wrap through the top of the table.
module stage_mem_update_ctrl
  import stage_mem_pkg::*;
#(
  parameter int              STAGE_ID  = 0,
  parameter int              DATA      = 72,
  parameter int              ADDR      = 10,
  parameter logic [DATA-1:0] CLR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  stage_mem_update_ctrl_if.slave  bus,
  output logic                    mem_wr,
  output logic [ADDR-1:0]         mem_addr,
  output logic [DATA-1:0]         mem_din,
  input  logic [DATA-1:0]         mem_dout,
  output logic                    busy,
  output logic                    clr_done,
  output logic                    cmd_err
);

  if (STAGE_ID < 0) begin : g_bad_stage_id
  end

  state_e          state_q;
  logic            rd_wait_q;
  logic [ADDR-1:0] addr_q;
  logic [ADDR-1:0] last_q;
  logic [DATA-1:0] data_q;
  logic [ADDR-1:0] cnt_q;

  logic            cmd_ready_q;
  logic            rsp_valid_q;
  logic [ADDR-1:0] rsp_addr_q;
  logic [DATA-1:0] rsp_data_q;
  logic            mem_wr_q;
  logic [ADDR-1:0] mem_addr_q;
  logic [DATA-1:0] mem_din_q;
  logic            busy_q;
  logic            clr_done_q;
  logic            cmd_err_q;

  logic accept;
  assign accept = bus.cmd_valid && cmd_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_wait_q   <= 1'b0;
      addr_q      <= '0;
      last_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      busy_q      <= 1'b0;
      clr_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      mem_wr_q   <= 1'b0;
      clr_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            addr_q <= bus.cmd_addr;
            last_q <= bus.cmd_last;
            data_q <= bus.cmd_data;
            cnt_q  <= bus.cmd_addr;
            case (bus.cmd_op)
              OP_WR: begin
                state_q     <= ST_WRITE;
                cmd_ready_q <= 1'b0;
                busy_q      <= 1'b1;
              end
              OP_RD: begin
                state_q     <= ST_RD_ISSUE;
                cmd_ready_q <= 1'b0;
                busy_q      <= 1'b1;
              end
              OP_CLR: begin
                state_q     <= ST_CLEAR;
                cmd_ready_q <= 1'b0;
                busy_q      <= 1'b1;
              end
              default: cmd_err_q <= 1'b1;
            endcase
          end
        end
        ST_WRITE: begin
          mem_wr_q   <= 1'b1;
          mem_addr_q <= addr_q;
          mem_din_q  <= data_q;
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
        end
        ST_RD_ISSUE: begin
          mem_addr_q <= addr_q;
          rd_wait_q  <= 1'b1;
          state_q    <= ST_RD_CAPT;
        end
        ST_RD_CAPT: begin
          // mem_addr is registered, so RAM data is valid one cycle into RD_CAPT
          if (rd_wait_q) begin
            rd_wait_q <= 1'b0;
          end else begin
            rsp_data_q  <= mem_dout;
            rsp_addr_q  <= addr_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          mem_wr_q   <= 1'b1;
          mem_addr_q <= cnt_q;
          mem_din_q  <= CLR_VALUE;
          cnt_q      <= cnt_q + ADDR'(1);
          if (cnt_q == last_q) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;
  assign mem_wr        = mem_wr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_din       = mem_din_q;
  assign busy          = busy_q;
  assign clr_done      = clr_done_q;
  assign cmd_err       = cmd_err_q;

endmodule

// File: doc/stage_mem_update_ctrl.md
Name: stage_mem_update_ctrl

Overview:
- Control-plane sequencer for one lookup stage's true-dual-port table RAM.
- Owns the RAM's port B. Port A stays with the lookup pipeline.
- Accepts single-word write, single-word read-back and range-clear commands over a valid/ready interface.
- Returns read data over a valid/ready response interface.

Parameters:
- STAGE_ID, 0, stage index; used only in simulation messages.
- DATA, 72, table word width in bits; must match the RAM.
- ADDR, 10, table address width; table depth is 2**ADDR.
- CLR_VALUE, 0, word written by range-clear (DATA bits).

Ports:
- clk  in  1  single clock; also drives the RAM's b_clk.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts the command this cycle.
- cmd_op  in  2  00 write, 01 read, 10 clear range, 11 reserved.
- cmd_addr  in  ADDR  target address, or first address for clear.
- cmd_last  in  ADDR  last address for clear, inclusive; ignored otherwise.
- cmd_data  in  DATA  write data; ignored otherwise.
- rsp_valid  out  1  read-back data valid.
- rsp_ready  in  1  consumer takes the response.
- rsp_addr  out  ADDR  address of the read-back.
- rsp_data  out  DATA  read-back word.
- mem_wr  out  1  to RAM b_wr.
- mem_addr  out  ADDR  to RAM b_addr.
- mem_din  out  DATA  to RAM b_din.
- mem_dout  in  DATA  from RAM b_dout; 1-cycle read latency.
- busy  out  1  high whenever the FSM is not in IDLE.
- clr_done  out  1  one-cycle pulse after the final clear write.
- cmd_err  out  1  one-cycle pulse when a reserved op is accepted.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Applies to cmd_ready, rsp_valid, mem_wr, mem_addr, mem_din, rsp_addr, rsp_data, busy, clr_done and cmd_err.
- cmd_ready is 1 only in IDLE. It rises in the first cycle after rst deasserts. A command is accepted on a clk edge where cmd_valid and cmd_ready are both 1.
- All outputs are registered. mem_wr is 0 in every state except WRITE and CLEAR.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_CAPT, RSP, CLEAR.
- IDLE:
  - write accepted -> WRITE
  - read accepted -> RD_ISSUE
  - clear accepted -> CLEAR; the clear counter is loaded with cmd_addr
  - reserved op accepted -> cmd_err=1 for one cycle; the FSM stays in IDLE
- WRITE, one cycle: mem_wr=1, mem_addr=cmd_addr, mem_din=cmd_data. Then -> IDLE.
  - Latency: command accepted at edge T; RAM written at edge T+2. cmd_ready is back at 1 at T+2.
- RD_ISSUE, one cycle: mem_wr=0, mem_addr=cmd_addr. Then -> RD_CAPT.
- RD_CAPT: on its edge, mem_dout is latched into rsp_data, cmd_addr into rsp_addr, and rsp_valid is set to 1. Then -> RSP.
- RSP: rsp_valid, rsp_data and rsp_addr hold stable until rsp_valid and rsp_ready are both 1 at an edge. On that edge rsp_valid clears and the FSM -> IDLE.
  - rsp_ready asserted early is ignored.
  - Minimum command-to-response latency: 3 edges.
- CLEAR: one write per cycle. mem_wr=1, mem_din=CLR_VALUE, mem_addr=counter. The counter increments modulo 2**ADDR.
  - Word count is ((cmd_last - cmd_addr) mod 2**ADDR) + 1. cmd_last < cmd_addr wraps through the top of the table.
  - cmd_last == cmd_addr writes exactly one word.
  - cmd_last == cmd_addr - 1 (mod 2**ADDR) clears the whole table.
  - After the write to cmd_last -> IDLE, and clr_done pulses on the same edge that enters IDLE.
- Command fields are captured at acceptance. Later changes on cmd_* do not affect an operation in flight.
- Port A collisions: the controller performs no address hazard checking against port A. The lookup pipeline sees either the old or the new word, per the RAM's read behaviour. Software quiesces or double-buffers if it needs atomic updates.
- Reset mid-operation: asynchronous return to IDLE. mem_wr drops immediately. A partially completed clear is abandoned (no clr_done), and a pending response is discarded.
- There is no internal command queue. Back-pressure comes from cmd_ready alone.

Decomposition:
- Package stage_mem_pkg:
  - op encodings: OP_WR, OP_RD, OP_CLR, OP_RSV
  - FSM state enum
  - localparam DEPTH = 2**ADDR helper
- No sub-module needed. The response holding register is kept inline.
- The top-level stage wrapper instantiates this block next to the RAM and connects mem_* to port B.

Test Plan:
- Write then read: write addr 0x005, data 0x12_3456789A_BCDEF012; then read 0x005 -> rsp_valid 3 edges after acceptance, rsp_addr 0x005, rsp_data equal to the written word.
- Response back-pressure: read 0x3FF with rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stay stable; cmd_ready stays 0; a single handshake on release; cmd_ready=1 on the next cycle.
- Range clear with wrap: preload 0x3FE, 0x3FF, 0x000, 0x001 with 0xAA; clear from 0x3FE to 0x001 -> exactly 4 mem_wr cycles at addresses 0x3FE, 0x3FF, 0x000, 0x001; clr_done pulses once; 0x002 is untouched.
- Single-word and full-table clear: clear 0x010 to 0x010 -> 1 write. Clear 0x001 to 0x000 -> 1024 writes, busy=1 for 1024 cycles.
- Reserved op: cmd_op=11 -> cmd_err pulses 1 cycle, no mem_wr, cmd_ready stays 1.
- Reset mid-clear: assert rst after 5 writes of a 100-word clear -> mem_wr=0 immediately, no clr_done, cmd_ready=1 on the first cycle after rst deasserts, and a subsequent write succeeds.
